// File: rtl/peak_report_if.sv
// Peak-list stream in, averaged phase-difference result out, plus sticky overflow flag.
interface peak_report_if #(parameter int WIDTH = 16);
    logic             sink_sop;
    logic             sink_eop;
    logic             sink_valid;
    logic [31:0]      sink_freq;
    logic [WIDTH-1:0] sink_mag;
    logic [15:0]      sink_phaseA;
    logic [15:0]      sink_phaseB;
    logic             source_valid;
    logic             source_ready;
    logic [31:0]      source_freq;
    logic [WIDTH-1:0] source_mag;
    logic [15:0]      source_dphase;
    logic             overflow;

    modport master (
        output sink_sop, sink_eop, sink_valid, sink_freq, sink_mag, sink_phaseA, sink_phaseB,
        output source_ready,
        input  source_valid, source_freq, source_mag, source_dphase, overflow
    );

    modport slave (
        input  sink_sop, sink_eop, sink_valid, sink_freq, sink_mag, sink_phaseA, sink_phaseB,
        input  source_ready,
        output source_valid, source_freq, source_mag, source_dphase, overflow
    );
endinterface

// File: rtl/peak_report.sv
// Picks the strongest peak per packet, wraps its phase difference B-A into [-pi, pi)
// and averages it over 2^LOG_RUNS packets into a held valid/ready result register.
//
// state   | meaning
// IDLE    | waiting for a valid sop beat
// COLLECT | inside a packet, tracking the max-magnitude entry
// FINISH  | one cycle: wrap dphi, accumulate, maybe emit result
module peak_report #(
    parameter int WIDTH    = 16,
    parameter int LOG_RUNS = 2
) (
    input  logic        clk,
    input  logic        reset,
    peak_report_if.slave bus
);
    localparam int AW = 16 + LOG_RUNS;
    localparam int CW = (LOG_RUNS > 0) ? LOG_RUNS : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'((1 << LOG_RUNS) - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load_first;
    logic               w_load_better;

    logic [31:0]        r_freq;
    logic [WIDTH-1:0]   r_mag;
    logic [15:0]        r_pa;
    logic [15:0]        r_pb;

    logic signed [AW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;

    logic               r_src_valid;
    logic [31:0]        r_src_freq;
    logic [WIDTH-1:0]   r_src_mag;
    logic [15:0]        r_src_dphase;
    logic               r_overflow;

    logic signed [17:0] w_diff;
    logic signed [17:0] w_wrapped;
    logic signed [15:0] w_dphi;
    logic signed [AW-1:0] w_acc_sum;
    logic signed [AW-1:0] w_mean;
    logic               w_finish;
    logic               w_done;
    logic               w_hs;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_first  = 1'b0;
        w_load_better = 1'b0;
        // A sop beat restarts a packet from any state, dropping any partial one.
        if (bus.sink_valid && bus.sink_sop) begin
            w_load_first = 1'b1;
            w_state_nxt  = bus.sink_eop ? FINISH : COLLECT;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                COLLECT: begin
                    if (bus.sink_valid) begin
                        w_load_better = (bus.sink_mag > r_mag);
                        if (bus.sink_eop) w_state_nxt = FINISH;
                    end
                end
                FINISH:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_freq <= '0;
            r_mag  <= '0;
            r_pa   <= '0;
            r_pb   <= '0;
        end else if (w_load_first || w_load_better) begin
            r_freq <= bus.sink_freq;
            r_mag  <= bus.sink_mag;
            r_pa   <= bus.sink_phaseA;
            r_pb   <= bus.sink_phaseB;
        end
    end

    assign w_diff = $signed({{2{r_pb[15]}}, r_pb}) - $signed({{2{r_pa[15]}}, r_pa});

    always_comb begin
        w_wrapped = w_diff;
        if (w_diff >= 18'sd25736)
            w_wrapped = w_diff - 18'sd51472;
        else if (w_diff < -18'sd25736)
            w_wrapped = w_diff + 18'sd51472;
    end

    assign w_dphi    = w_wrapped[15:0];
    assign w_acc_sum = r_acc + AW'(w_dphi);
    assign w_mean    = w_acc_sum >>> LOG_RUNS;
    assign w_finish  = (r_state == FINISH);
    assign w_done    = w_finish && (r_cnt == RUN_LAST);
    assign w_hs      = r_src_valid && bus.source_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_done) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_finish) begin
            r_acc <= w_acc_sum;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A result finishing while an unaccepted one is held is dropped, not queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_valid  <= 1'b0;
            r_src_freq   <= '0;
            r_src_mag    <= '0;
            r_src_dphase <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_done && (!r_src_valid || w_hs)) begin
                r_src_valid  <= 1'b1;
                r_src_freq   <= r_freq;
                r_src_mag    <= r_mag;
                r_src_dphase <= w_mean[15:0];
            end else if (w_hs) begin
                r_src_valid <= 1'b0;
            end
            if (w_done && r_src_valid && !w_hs)
                r_overflow <= 1'b1;
        end
    end

    assign bus.source_valid  = r_src_valid;
    assign bus.source_freq   = r_src_freq;
    assign bus.source_mag    = r_src_mag;
    assign bus.source_dphase = r_src_dphase;
    assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_peak_report.sv
// Directed bench for peak_report: one instance averaging 1 packet, one averaging 4.
module tb_peak_report;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        s_sop = 1'b0, s_eop = 1'b0, s_valid = 1'b0, s_ready = 1'b1, sel = 1'b0;
    logic [31:0] s_freq = '0;
    logic [15:0] s_mag = '0, s_pa = '0, s_pb = '0;
    int total = 0;
    int bad = 0;
    int hs2 = 0;
    int hs2_start;

    peak_report_if #(.WIDTH(16)) b0 ();
    peak_report_if #(.WIDTH(16)) b2 ();

    assign b0.sink_sop = s_sop;      assign b2.sink_sop = s_sop;
    assign b0.sink_eop = s_eop;      assign b2.sink_eop = s_eop;
    assign b0.sink_valid = s_valid & ~sel;
    assign b2.sink_valid = s_valid & sel;
    assign b0.sink_freq = s_freq;    assign b2.sink_freq = s_freq;
    assign b0.sink_mag = s_mag;      assign b2.sink_mag = s_mag;
    assign b0.sink_phaseA = s_pa;    assign b2.sink_phaseA = s_pa;
    assign b0.sink_phaseB = s_pb;    assign b2.sink_phaseB = s_pb;
    assign b0.source_ready = s_ready;
    assign b2.source_ready = s_ready;

    peak_report #(.WIDTH(16), .LOG_RUNS(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    peak_report #(.WIDTH(16), .LOG_RUNS(2)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

    always @(posedge clk) if (b2.source_valid && b2.source_ready) hs2 = hs2 + 1;

    task automatic beat(input logic sop, input logic eop, input logic [31:0] f,
                        input logic [15:0] m, input logic [15:0] pa, input logic [15:0] pb);
        s_sop = sop; s_eop = eop; s_freq = f; s_mag = m; s_pa = pa; s_pb = pb; s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        total++; if (b0.source_valid !== 1'b0) begin bad++; $display("FAIL rst_valid0 got=%0h want=0", b0.source_valid); end
        total++; if (b0.source_dphase !== 16'h0) begin bad++; $display("FAIL rst_dphase0 got=%0h want=0", b0.source_dphase); end
        total++; if (b0.source_freq !== 32'h0) begin bad++; $display("FAIL rst_freq0 got=%0h want=0", b0.source_freq); end
        total++; if (b2.source_mag !== 16'h0) begin bad++; $display("FAIL rst_mag2 got=%0h want=0", b2.source_mag); end
        total++; if (b2.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf2 got=%0h want=0", b2.overflow); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_max;
        sel = 1'b0; s_ready = 1'b1;
        beat(1, 0, 32'd1000, 16'd5, 16'd0, 16'd100);
        beat(0, 0, 32'd1001, 16'd9, 16'd0, 16'd2000);
        idle(1);
        beat(0, 0, 32'd1002, 16'd9, 16'd0, 16'd3000);
        beat(0, 1, 32'd1003, 16'd3, 16'd0, 16'd4000);
        idle(1);
        total++; if (b0.source_valid !== 1'b1) begin bad++; $display("FAIL max_valid got=%0h want=1", b0.source_valid); end
        total++; if (b0.source_mag !== 16'd9) begin bad++; $display("FAIL max_mag got=%0d want=9", b0.source_mag); end
        total++; if (b0.source_dphase !== 16'd2000) begin bad++; $display("FAIL max_dphase got=%0d want=2000", b0.source_dphase); end
        total++; if (b0.source_freq !== 32'd1001) begin bad++; $display("FAIL max_freq got=%0d want=1001", b0.source_freq); end
        idle(1);
        total++; if (b0.source_valid !== 1'b0) begin bad++; $display("FAIL max_taken got=%0h want=0", b0.source_valid); end
    endtask

    task automatic test_back_to_back;
        sel = 1'b0; s_ready = 1'b1;
        beat(1, 1, 32'd1, 16'd1, -16'sd25000, 16'sd25000);
        beat(1, 1, 32'd2, 16'd1, 16'sd25000, -16'sd25000);
        total++; if (b0.source_dphase !== 16'hFA40) begin bad++; $display("FAIL wrap_pos got=%0h want=fa40", b0.source_dphase); end
        beat(1, 1, 32'd3, 16'd1, 16'd0, 16'd25736);
        total++; if (b0.source_dphase !== 16'h05C0) begin bad++; $display("FAIL wrap_neg got=%0h want=05c0", b0.source_dphase); end
        total++; if (b0.source_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0h want=1", b0.source_valid); end
        beat(1, 1, 32'd4, 16'd1, 16'd25736, 16'd0);
        total++; if ({b0.source_freq, b0.source_dphase} !== {32'd3, 16'h9B78}) begin bad++; $display("FAIL wrap_pi got=%0h/%0h want=3/9b78", b0.source_freq, b0.source_dphase); end
        beat(1, 1, 32'd5, 16'd1, 16'd0, 16'd25735);
        total++; if ({b0.source_freq, b0.source_dphase} !== {32'd4, 16'h9B78}) begin bad++; $display("FAIL wrap_mpi got=%0h/%0h want=4/9b78", b0.source_freq, b0.source_dphase); end
        idle(1);
        total++; if (b0.source_dphase !== 16'd25735) begin bad++; $display("FAIL wrap_below_pi got=%0d want=25735", b0.source_dphase); end
        total++; if (b0.overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0h want=0", b0.overflow); end
        idle(1);
    endtask

    task automatic test_truncated;
        sel = 1'b0; s_ready = 1'b1;
        beat(0, 1, 32'd5, 16'd77, 16'd0, 16'd55);
        idle(1);
        total++; if (b0.source_valid !== 1'b0) begin bad++; $display("FAIL idle_eop got=%0h want=0", b0.source_valid); end
        beat(1, 0, 32'd50, 16'd50, 16'd0, 16'd500);
        beat(0, 0, 32'd60, 16'd60, 16'd0, 16'd600);
        beat(1, 0, 32'd7, 16'd3, 16'd0, 16'd33);
        beat(0, 0, 32'd9, 16'd2, 16'd0, 16'd22);
        beat(0, 1, 32'd8, 16'd4, 16'd0, 16'd44);
        idle(1);
        total++; if (b0.source_valid !== 1'b1) begin bad++; $display("FAIL trunc_valid got=%0h want=1", b0.source_valid); end
        total++; if ({b0.source_freq, b0.source_mag, b0.source_dphase} !== {32'd8, 16'd4, 16'd44}) begin
            bad++; $display("FAIL trunc_payload got=%0d/%0d/%0d want=8/4/44", b0.source_freq, b0.source_mag, b0.source_dphase); end
        idle(1);
    endtask

    task automatic test_average;
        sel = 1'b1; s_ready = 1'b1;
        hs2_start = hs2;
        beat(1, 1, 32'd11, 16'd10, 16'd0, 16'd100);  idle(1);
        beat(1, 1, 32'd22, 16'd20, 16'd0, 16'd200);  idle(1);
        beat(1, 1, 32'd33, 16'd30, 16'd0, 16'd300);  idle(1);
        total++; if (b2.source_valid !== 1'b0) begin bad++; $display("FAIL avg_early got=%0h want=0", b2.source_valid); end
        beat(1, 0, 32'd40, 16'd7, 16'd0, 16'd50);
        beat(0, 1, 32'd44, 16'd8, 16'd0, 16'hFFFF);
        idle(1);
        total++; if (b2.source_valid !== 1'b1) begin bad++; $display("FAIL avg_valid got=%0h want=1", b2.source_valid); end
        total++; if (b2.source_dphase !== 16'd149) begin bad++; $display("FAIL avg_dphase got=%0d want=149", b2.source_dphase); end
        total++; if ({b2.source_freq, b2.source_mag} !== {32'd44, 16'd8}) begin bad++; $display("FAIL avg_peak got=%0d/%0d want=44/8", b2.source_freq, b2.source_mag); end
        idle(3);
        total++; if (hs2 - hs2_start !== 1) begin bad++; $display("FAIL avg_count got=%0d want=1", hs2 - hs2_start); end
        beat(1, 1, 32'd1, 16'd1, 16'd0, 16'hFFFF);
        beat(1, 1, 32'd1, 16'd1, 16'd0, 16'hFFFF);
        beat(1, 1, 32'd1, 16'd1, 16'd0, 16'hFFFF);
        beat(1, 1, 32'd2, 16'd2, 16'd0, 16'hFFFE);
        idle(1);
        total++; if ({b2.source_valid, b2.source_dphase} !== {1'b1, 16'hFFFE}) begin bad++; $display("FAIL avg_floor got=%0h/%0h want=1/fffe", b2.source_valid, b2.source_dphase); end
        idle(2);
    endtask

    task automatic test_backpressure;
        sel = 1'b0; s_ready = 1'b0;
        beat(1, 1, 32'd100, 16'd1, 16'd0, 16'd11);
        idle(1);
        total++; if ({b0.source_valid, b0.source_dphase} !== {1'b1, 16'd11}) begin bad++; $display("FAIL bp_first got=%0h/%0d want=1/11", b0.source_valid, b0.source_dphase); end
        beat(1, 1, 32'd200, 16'd2, 16'd0, 16'd22);
        idle(1);
        total++; if (b0.overflow !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%0h want=1", b0.overflow); end
        total++; if ({b0.source_freq, b0.source_dphase} !== {32'd100, 16'd11}) begin bad++; $display("FAIL bp_hold got=%0d/%0d want=100/11", b0.source_freq, b0.source_dphase); end
        beat(1, 1, 32'd300, 16'd3, 16'd0, 16'd33);
        s_ready = 1'b1;
        idle(1);
        total++; if ({b0.source_valid, b0.source_freq, b0.source_dphase} !== {1'b1, 32'd300, 16'd33}) begin
            bad++; $display("FAIL bp_same_cycle got=%0h/%0d/%0d want=1/300/33", b0.source_valid, b0.source_freq, b0.source_dphase); end
        total++; if (b0.overflow !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%0h want=1", b0.overflow); end
        idle(1);
        total++; if (b0.source_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0h want=0", b0.source_valid); end
    endtask

    task automatic test_reset_mid;
        sel = 1'b1; s_ready = 1'b1;
        beat(1, 1, 32'd90, 16'd9, 16'd0, 16'd1000);  idle(1);
        beat(1, 1, 32'd91, 16'd9, 16'd0, 16'd2000);  idle(1);
        beat(1, 0, 32'd92, 16'd5, 16'd0, 16'd3000);
        reset = 1'b1;
        #2;
        total++; if ({b0.source_valid, b0.overflow, b0.source_freq, b0.source_mag, b0.source_dphase} !== 66'h0) begin
            bad++; $display("FAIL rstmid_out0 got=%0h want=0", {b0.source_valid, b0.overflow, b0.source_freq, b0.source_mag, b0.source_dphase}); end
        total++; if ({b2.source_valid, b2.overflow, b2.source_freq, b2.source_mag, b2.source_dphase} !== 66'h0) begin
            bad++; $display("FAIL rstmid_out2 got=%0h want=0", {b2.source_valid, b2.overflow, b2.source_freq, b2.source_mag, b2.source_dphase}); end
        idle(2);
        reset = 1'b0;
        idle(1);
        beat(1, 1, 32'd1, 16'd1, 16'd0, 16'd4);   idle(1);
        beat(1, 1, 32'd2, 16'd2, 16'd0, 16'd8);   idle(1);
        beat(1, 1, 32'd3, 16'd3, 16'd0, 16'd12);  idle(1);
        total++; if (b2.source_valid !== 1'b0) begin bad++; $display("FAIL rstmid_early got=%0h want=0", b2.source_valid); end
        beat(1, 1, 32'd4, 16'd4, 16'd0, 16'd16);  idle(1);
        total++; if ({b2.source_valid, b2.source_freq, b2.source_mag, b2.source_dphase} !== {1'b1, 32'd4, 16'd4, 16'd10}) begin
            bad++; $display("FAIL rstmid_avg got=%0h/%0d/%0d/%0d want=1/4/4/10", b2.source_valid, b2.source_freq, b2.source_mag, b2.source_dphase); end
        idle(2);
    endtask

    initial begin
        test_reset;
        test_max;
        test_back_to_back;
        test_truncated;
        test_average;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
